// File: rtl/op_sequencer.sv
// Tick-driven ALU request sequencer: latches switch operands, issues one ALU op per tick, shows result on LEDs.
// Optional build macro LED_OP_TAG_EN: prefix the LED value with the producing opcode.
module op_sequencer #(
  parameter int NUM_OPS = 5,
  parameter int OP_W    = 4,
  parameter int DATA_W  = 32,
  parameter int LED_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              new_op_i,
  input  logic [15:0]       sw_i,
  output logic              op_valid_o,
  output logic [OP_W-1:0]   op_code_o,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  input  logic              op_ready_i,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  input  logic              zero_i,
  output logic [LED_W-1:0]  led_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_code_q, op_code_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              overrun_q, overrun_d;

  logic [LED_W-1:0]  led_result;
  logic [LED_W-1:0]  led_timeout;
  logic [OP_W-1:0]   idx_next;
  logic              unused_res_bits;

`ifdef LED_OP_TAG_EN
  assign led_result      = {op_code_q[3:0], zero_i, res_data_i[LED_W-6:0]};
  assign led_timeout     = {op_code_q[3:0], {(LED_W-4){1'b1}}};
  assign unused_res_bits = ^res_data_i[DATA_W-1:LED_W-5];
`else
  assign led_result      = {zero_i, res_data_i[LED_W-2:0]};
  assign led_timeout     = {LED_W{1'b1}};
  assign unused_res_bits = ^res_data_i[DATA_W-1:LED_W-1];
`endif

  assign idx_next = (idx_q == OP_W'(NUM_OPS - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      op_code_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      led_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      op_code_q <= op_code_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      led_q     <= led_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    op_code_d = op_code_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    led_d     = led_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (new_op_i) begin
          op_a_d    = DATA_W'(sw_i[7:0]);
          op_b_d    = DATA_W'(sw_i[15:8]);
          op_code_d = idx_q;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (new_op_i) overrun_d = 1'b1;
        if (op_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ticks are dropped here even in the cycle that returns to IDLE.
        if (new_op_i) overrun_d = 1'b1;
        if (res_valid_i) begin
          led_d   = led_result;
          idx_d   = idx_next;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          led_d   = led_timeout;
          idx_d   = idx_next;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign op_valid_o = (state_q == S_ISSUE);
  assign busy_o     = (state_q != S_IDLE);
  assign op_code_o  = op_code_q;
  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign led_o      = led_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: table vectors, directed corner sequences, randomized ops vs. a transaction model.
module tb_op_sequencer;
  localparam int NUM_OPS = 5;
  localparam int TIMEOUT = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        new_op_i = 1'b0;
  logic [15:0] sw_i = '0;
  logic        op_valid_o;
  logic [3:0]  op_code_o;
  logic [31:0] op_a_o, op_b_o;
  logic        op_ready_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_data_i = '0;
  logic        zero_i = 1'b0;
  logic [15:0] led_o;
  logic        busy_o, overrun_o;

  op_sequencer #(.NUM_OPS(NUM_OPS), .OP_W(4), .DATA_W(32), .LED_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .new_op_i(new_op_i), .sw_i(sw_i),
    .op_valid_o(op_valid_o), .op_code_o(op_code_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .op_ready_i(op_ready_i), .res_valid_i(res_valid_i), .res_data_i(res_data_i), .zero_i(zero_i),
    .led_o(led_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;
  int ops_done = 0;
  logic exp_ovr = 1'b0;
  logic [15:0] exp_led_q = '0;

  typedef struct {
    logic [15:0] sw;
    int          rdy;
    int          res;
    logic [31:0] data;
    logic        z;
    logic [3:0]  code;
    logic [15:0] led_plain;
    logic [15:0] led_tag;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [15:0] led_fn(input logic [3:0] code, input logic [31:0] data,
                                         input logic z, input logic to);
`ifdef LED_OP_TAG_EN
    if (to) return {code, 12'hFFF};
    return {code, z, data[10:0]};
`else
    if (to) return 16'hFFFF;
    return {z, data[14:0]};
`endif
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_valid", op_valid_o, 0);
    chk("rst_code", op_code_o, 0);
    chk("rst_ab", {op_a_o, op_b_o}, 0);
    chk("rst_led", led_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovr", overrun_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ops_done = 0;
    exp_ovr = 1'b0;
    exp_led_q = '0;
  endtask

  // res_dly < 0 means the ALU never answers (timeout path).
  task automatic do_op(input logic [15:0] sw, input int rdy_dly, input int res_dly,
                       input logic [31:0] data, input logic z, input logic extra,
                       input logic [3:0] ecode, input logic [15:0] eled);
    logic [31:0] ea, eb;
    ea = {24'b0, sw[7:0]};
    eb = {24'b0, sw[15:8]};
    sw_i = sw;
    new_op_i = 1'b1;
    @(posedge clk_i); #1;
    new_op_i = 1'b0;
    sw_i = 16'($urandom);
    chk("req_valid", op_valid_o, 1);
    chk("req_busy", busy_o, 1);
    chk("req_code", op_code_o, ecode);
    chk("req_a", op_a_o, ea);
    chk("req_b", op_b_o, eb);
    if (rdy_dly > 0) begin
      res_valid_i = 1'b1;
      res_data_i = $urandom;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(posedge clk_i); #1;
      res_valid_i = 1'b0;
      chk("hold_valid", op_valid_o, 1);
      chk("hold_req", {op_code_o, op_a_o, op_b_o}, {ecode, ea, eb});
      if (i == 0) chk("issue_res_ignored", led_o, exp_led_q);
    end
    op_ready_i = 1'b1;
    @(posedge clk_i); #1;
    op_ready_i = 1'b0;
    chk("acc_valid_low", op_valid_o, 0);
    chk("acc_busy", busy_o, 1);
    new_op_i = extra;
    if (extra) exp_ovr = 1'b1;
    if (res_dly >= 0) begin
      for (int i = 0; i < res_dly; i++) begin
        @(posedge clk_i); #1;
        new_op_i = 1'b0;
        chk("wait_led", led_o, exp_led_q);
      end
      res_valid_i = 1'b1;
      res_data_i = data;
      zero_i = z;
      @(posedge clk_i); #1;
      res_valid_i = 1'b0;
      new_op_i = 1'b0;
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        @(posedge clk_i); #1;
        new_op_i = 1'b0;
        if (i == TIMEOUT - 2) begin
          chk("to_still_busy", busy_o, 1);
          chk("to_led_held", led_o, exp_led_q);
        end
      end
    end
    chk("done_led", led_o, eled);
    chk("done_idle", busy_o, 0);
    chk("done_ovr", overrun_o, exp_ovr);
    exp_led_q = eled;
    if (res_dly < 0) begin
      res_valid_i = 1'b1;
      res_data_i = $urandom;
      @(posedge clk_i); #1;
      res_valid_i = 1'b0;
      chk("late_res_ignored", led_o, eled);
    end
  endtask

  initial begin
    logic [15:0] sw;
    logic [31:0] data;
    logic [3:0]  code;
    int          rdy, res;
    logic        z, extra;

    vecs[0] = '{16'h0305, 0, 3, 32'd8,         1'b0, 4'd0, 16'h0008, 16'h0008};
    vecs[1] = '{16'h12AB, 2, 1, 32'h0001_FFFF, 1'b0, 4'd1, 16'h7FFF, 16'h17FF};
    vecs[2] = '{16'hFF00, 0, 0, 32'h0,         1'b1, 4'd2, 16'h8000, 16'h2800};
    vecs[3] = '{16'h00FF, 1, 5, 32'hDEADBEEF,  1'b0, 4'd3, 16'h3EEF, 16'h36EF};
    vecs[4] = '{16'hA55A, 0, 2, 32'h1234,      1'b1, 4'd4, 16'h9234, 16'h4A34};
    vecs[5] = '{16'h0102, 0, 0, 32'h5,         1'b0, 4'd0, 16'h0005, 16'h0005};

    #3;
    do_reset();

    foreach (vecs[k]) begin
`ifdef LED_OP_TAG_EN
      do_op(vecs[k].sw, vecs[k].rdy, vecs[k].res, vecs[k].data, vecs[k].z, 1'b0, vecs[k].code, vecs[k].led_tag);
`else
      do_op(vecs[k].sw, vecs[k].rdy, vecs[k].res, vecs[k].data, vecs[k].z, 1'b0, vecs[k].code, vecs[k].led_plain);
`endif
    end

    // Long ready stall: request must stay frozen for ten cycles.
    do_op(16'h4321, 10, 1, 32'h77, 1'b0, 1'b0, 4'd1, led_fn(4'd1, 32'h77, 1'b0, 1'b0));

    // Timeout from a fresh reset, then the next opcode follows.
    do_reset();
    do_op(16'h0909, 0, -1, 32'h0, 1'b0, 1'b0, 4'd0, led_fn(4'd0, 32'h0, 1'b0, 1'b1));
    do_op(16'h0102, 0, 1, 32'h42, 1'b1, 1'b0, 4'd1, led_fn(4'd1, 32'h42, 1'b1, 1'b0));

    // Tick during WAIT is dropped and overrun sticks.
    do_op(16'h0A0B, 1, 2, 32'h99, 1'b0, 1'b1, 4'd2, led_fn(4'd2, 32'h99, 1'b0, 1'b0));
    @(posedge clk_i); #1;
    chk("ovr_no_second_req", {op_valid_o, busy_o}, 0);
    chk("ovr_led_once", led_o, led_fn(4'd2, 32'h99, 1'b0, 1'b0));
    do_op(16'h0C0D, 0, 0, 32'h3, 1'b0, 1'b1, 4'd3, led_fn(4'd3, 32'h3, 1'b0, 1'b0));
    @(posedge clk_i); #1;
    chk("ovr_wait_exit_drop", {op_valid_o, busy_o, overrun_o}, 3'b001);

    // Reset in the middle of WAIT clears everything at once.
    do_reset();
    do_op(16'h0305, 0, 3, 32'd8, 1'b0, 1'b0, 4'd0, led_fn(4'd0, 32'd8, 1'b0, 1'b0));
    sw_i = 16'h5566;
    new_op_i = 1'b1;
    @(posedge clk_i); #1;
    new_op_i = 1'b1;
    op_ready_i = 1'b1;
    @(posedge clk_i); #1;
    new_op_i = 1'b0;
    op_ready_i = 1'b0;
    chk("pre_rst_ovr", overrun_o, 1);
    chk("pre_rst_led", led_o, 16'h0008);
    do_reset();
    do_op(16'h0201, 0, 0, 32'h11, 1'b0, 1'b0, 4'd0, led_fn(4'd0, 32'h11, 1'b0, 1'b0));
    ops_done = 1;

    for (int k = 0; k < 30; k++) begin
      sw    = 16'($urandom);
      rdy   = int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) res = -1;
      else res = int'($urandom_range(0, 6));
      data  = $urandom;
      z     = 1'($urandom_range(0, 1));
      extra = ($urandom_range(0, 3) == 0);
      code  = 4'(ops_done % NUM_OPS);
      do_op(sw, rdy, res, data, z, extra, code, led_fn(code, data, z, res < 0));
      ops_done++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end
endmodule
